soc_bus_xbar: RTL and testbench

// - Parametrised shared-bus interconnect for the TinyRISC-V SoC.
// - Replaces point-to-point core-to-RAM wiring with N masters to M address-decoded slaves:
//   - masters: core data port, debug/loader;
//   - slaves: RAM, UART, GPIO, timer, interrupt controller.
// - One transaction in flight at a time.
// - Round-robin arbitration, slave ready handshake, unmapped-address error, slave timeout error.

---
 rtl/soc_bus_xbar.sv | 216 +++++++++++++++++++++
 tb/tb_soc_bus_xbar.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_xbar.sv
`default_nettype none
// ============================================================================
// Module   : soc_bus_xbar
// Purpose  : Round-robin N-master to M-slave address-decoded bus, one
//            transaction in flight, with unmapped-address and timeout errors.
// Revision : 1.0 - initial release
// ============================================================================
module soc_bus_xbar #(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_be_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [DATA_WIDTH-1:0]             m_rdata_o,
  output logic [NUM_SLAVES-1:0]             s_req_o,
  output logic                              s_we_o,
  output logic [BE_WIDTH-1:0]               s_be_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  input  logic [NUM_SLAVES-1:0]             s_ready_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_rdata_i
);

  localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [MIDX_W-1:0]     rr_ptr, owner;
  logic                  lat_we;
  logic [BE_WIDTH-1:0]   lat_be;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [CNT_W-1:0]      cnt;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  logic                  any_req;
  logic                  pick_found;
  logic [MIDX_W-1:0]     pick_idx;
  logic                  pick_we;
  logic [BE_WIDTH-1:0]   pick_be;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] pick_wdata;
  logic [SEL_BITS-1:0]   sel;
  logic                  sel_valid;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout_hit;
  logic                  access_done;

  assign any_req = |m_req_i;

  // Cyclic search starting at rr_ptr: first requester wins.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_MASTERS;
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!pick_found && (j == idx) && m_req_i[j]) begin
          pick_found = 1'b1;
          pick_idx   = MIDX_W'(j);
        end
      end
    end
  end

  always_comb begin
    pick_we    = 1'b0;
    pick_be    = '0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (int'(pick_idx) == j) begin
        pick_we    = m_we_i[j];
        pick_be    = m_be_i[j*BE_WIDTH +: BE_WIDTH];
        pick_addr  = m_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = m_wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sel = lat_addr[ADDR_WIDTH-1 -: SEL_BITS];

  // sel_valid stays low for indices that decode to no slave.
  always_comb begin
    sel_valid = 1'b0;
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (int'(sel) == j) begin
        sel_valid = 1'b1;
        sel_ready = s_ready_i[j];
        sel_rdata = s_rdata_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign access_done = !sel_valid || sel_ready || timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
      ST_ACCESS: if (access_done) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      owner      <= '0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner     <= pick_idx;
            lat_we    <= pick_we;
            lat_be    <= pick_be;
            lat_addr  <= pick_addr;
            lat_wdata <= pick_wdata;
            cnt       <= '0;
          end
        end
        ST_ACCESS: begin
          if (!sel_valid) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else if (sel_ready) begin
            resp_err   <= 1'b0;
            resp_rdata <= lat_we ? '0 : sel_rdata;
          end else if (timeout_hit) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          rr_ptr     <= MIDX_W'((int'(owner) + 1) % NUM_MASTERS);
          lat_we     <= 1'b0;
          lat_be     <= '0;
          lat_addr   <= '0;
          lat_wdata  <= '0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  // Grant is suppressed while reset is asserted so no master sees a phantom grant.
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_err_o    = '0;
    s_req_o    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if ((state == ST_IDLE) && any_req && rst_n && (int'(pick_idx) == k))
        m_gnt_o[k] = 1'b1;
      if ((state == ST_RESP) && (int'(owner) == k)) begin
        m_rvalid_o[k] = 1'b1;
        m_err_o[k]    = resp_err;
      end
    end
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if ((state == ST_ACCESS) && (int'(sel) == j))
        s_req_o[j] = 1'b1;
    end
  end

  assign m_rdata_o = (state == ST_RESP) ? resp_rdata : '0;
  assign s_we_o    = lat_we;
  assign s_be_o    = lat_be;
  assign s_addr_o  = lat_addr;
  assign s_wdata_o = lat_wdata;

endmodule
`default_nettype wire

// File: tb/tb_soc_bus_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_bus_xbar
// Purpose  : Directed and randomized self-checking bench for soc_bus_xbar.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_bus_xbar;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SB = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     m_req, m_we;
  logic [NM*BW-1:0]  m_be;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_gnt, m_rvalid, m_err;
  logic [DW-1:0]     m_rdata;
  logic [NS-1:0]     s_req;
  logic              s_we;
  logic [BW-1:0]     s_be;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [NS-1:0]     s_ready;
  logic [NS*DW-1:0]  s_rdata;

  always #5 clk = ~clk;

  soc_bus_xbar #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SEL_BITS(SB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_err_o(m_err), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_ready_i(s_ready), .s_rdata_i(s_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding transfer, described by who
  // owns it, where it goes, how many access cycles it has used, and its result.
  bit            mb_busy = 1'b0;
  bit            mb_resp = 1'b0;
  int            mb_rr   = 0;
  int            mb_own  = 0;
  int            mb_sel  = 0;
  int            mb_acc  = 0;
  logic          mb_we   = 1'b0;
  logic [BW-1:0] mb_be   = '0;
  logic [AW-1:0] mb_addr = '0;
  logic [DW-1:0] mb_wd   = '0;
  logic [DW-1:0] mb_rd   = '0;
  bit            mb_err  = 1'b0;

  function automatic int pick(input logic [NM-1:0] req, input int rr);
    for (int i = 0; i < NM; i++) begin
      if (req[(rr + i) % NM]) return (rr + i) % NM;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NM-1:0] e_gnt, e_rv, e_err;
    logic [DW-1:0] e_rd, e_wd;
    logic [NS-1:0] e_sreq;
    logic          e_we;
    logic [BW-1:0] e_be;
    logic [AW-1:0] e_addr;
    int            p;
    e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0; e_sreq = '0;
    e_we = 1'b0; e_be = '0; e_addr = '0; e_wd = '0;
    p = pick(m_req, mb_rr);
    if (!mb_busy) begin
      if (rst_n && p >= 0) e_gnt[p] = 1'b1;
    end else begin
      e_we = mb_we; e_be = mb_be; e_addr = mb_addr; e_wd = mb_wd;
      if (!mb_resp) begin
        if (mb_sel < NS) e_sreq[mb_sel] = 1'b1;
      end else begin
        e_rv[mb_own]  = 1'b1;
        e_err[mb_own] = mb_err;
        e_rd          = mb_rd;
      end
    end
    if (chk_en) begin
      check("m_gnt",    64'(m_gnt),    64'(e_gnt));
      check("m_rvalid", 64'(m_rvalid), 64'(e_rv));
      check("m_err",    64'(m_err),    64'(e_err));
      check("m_rdata",  64'(m_rdata),  64'(e_rd));
      check("s_req",    64'(s_req),    64'(e_sreq));
      check("s_we",     64'(s_we),     64'(e_we));
      check("s_be",     64'(s_be),     64'(e_be));
      check("s_addr",   64'(s_addr),   64'(e_addr));
      check("s_wdata",  64'(s_wdata),  64'(e_wd));
    end
    if (!rst_n) begin
      mb_busy = 1'b0; mb_resp = 1'b0; mb_rr = 0;
    end else if (!mb_busy) begin
      if (p >= 0) begin
        mb_busy = 1'b1; mb_resp = 1'b0; mb_own = p; mb_acc = 0;
        mb_we   = m_we[p];
        mb_be   = m_be[p*BW +: BW];
        mb_addr = m_addr[p*AW +: AW];
        mb_wd   = m_wdata[p*DW +: DW];
        mb_sel  = int'(mb_addr[AW-1 -: SB]);
      end
    end else if (!mb_resp) begin
      mb_acc++;
      if (mb_sel >= NS) begin
        mb_err = 1'b1; mb_rd = '0; mb_resp = 1'b1;
      end else if (s_ready[mb_sel]) begin
        mb_err = 1'b0; mb_rd = mb_we ? '0 : s_rdata[mb_sel*DW +: DW]; mb_resp = 1'b1;
      end else if (mb_acc == TO) begin
        mb_err = 1'b1; mb_rd = '0; mb_resp = 1'b1;
      end
    end else begin
      mb_busy = 1'b0; mb_resp = 1'b0; mb_rr = (mb_own + 1) % NM;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic new_req(input int k);
    logic [3:0] nib;
    case ($urandom % 8)
      0, 4:    nib = 4'h0;
      1:       nib = 4'h1;
      2:       nib = 4'h2;
      3, 6:    nib = 4'h3;
      5:       nib = 4'hF;
      default: nib = 4'($urandom);
    endcase
    m_req[k]             = 1'b1;
    m_we[k]              = 1'($urandom);
    m_be[k*BW +: BW]     = BW'($urandom);
    m_addr[k*AW +: AW]   = {nib, 28'($urandom)};
    m_wdata[k*DW +: DW]  = DW'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NM-1:0] gseen;
    int pr;
    rst_n = 1'b0; m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
    s_ready = '0; s_rdata = '0;
    gseen = '0; pr = 25;
    step();
    chk_en = 1'b1;
    m_req = 2'b11;
    settle();
    check("rst_gnt",    64'(m_gnt),    64'h0);
    check("rst_rvalid", 64'(m_rvalid), 64'h0);
    check("rst_sreq",   64'(s_req),    64'h0);
    step(); m_req = '0; rst_n = 1'b1;
    settle();

    // Read from slave 1, ready in the first access cycle
    step();
    m_req = 2'b01; m_we = 2'b00; m_be[0 +: BW] = 4'hF; m_addr[0 +: AW] = 32'h1000_0010;
    settle(); check("d1_gnt_T0", 64'(m_gnt), 64'h1);
    step(); m_req = '0; s_ready = 4'b0010; s_rdata[1*DW +: DW] = 32'hDEADBEEF;
    settle(); check("d1_sreq_T1", 64'(s_req), 64'h2); check("d1_saddr_T1", 64'(s_addr), 64'h1000_0010);
    step(); s_ready = '0;
    settle();
    check("d1_rvalid_T2", 64'(m_rvalid), 64'h1);
    check("d1_rdata_T2",  64'(m_rdata),  64'hDEADBEEF);
    check("d1_err_T2",    64'(m_err),    64'h0);
    step(); settle();
    check("d1_rvalid_T3", 64'(m_rvalid), 64'h0);
    check("d1_rdata_T3",  64'(m_rdata),  64'h0);

    // Write from master 1 to slave 2, three wait cycles then ready
    step();
    m_req = 2'b10; m_we = 2'b10; m_be[BW +: BW] = 4'b0011;
    m_addr[AW +: AW] = 32'h2000_0004; m_wdata[DW +: DW] = 32'h1234_5678;
    settle(); check("d2_gnt", 64'(m_gnt), 64'h2);
    for (int i = 0; i < 4; i++) begin
      step(); m_req = '0;
      s_ready = (i == 3) ? 4'b0100 : 4'b0000;
      s_rdata[2*DW +: DW] = 32'hCAFE_F00D;
      settle();
      check("d2_sreq_held", 64'(s_req), 64'h4);
      check("d2_sbe",       64'(s_be),  64'h3);
      check("d2_swdata",    64'(s_wdata), 64'h1234_5678);
    end
    step(); s_ready = '0;
    settle();
    check("d2_rvalid", 64'(m_rvalid), 64'h2);
    check("d2_rdata",  64'(m_rdata),  64'h0);
    check("d2_err",    64'(m_err),    64'h0);

    // Unmapped address: no slave selected, immediate error
    step(); m_req = 2'b01; m_we = 2'b00; m_addr[0 +: AW] = 32'hF000_0000;
    settle(); check("d3_gnt", 64'(m_gnt), 64'h1);
    step(); m_req = '0; s_ready = 4'b1111;
    settle(); check("d3_sreq", 64'(s_req), 64'h0);
    step(); s_ready = '0;
    settle();
    check("d3_rvalid", 64'(m_rvalid), 64'h1);
    check("d3_err",    64'(m_err),    64'h1);
    check("d3_rdata",  64'(m_rdata),  64'h0);

    // Timeout: slave 0 never ready, others ready but ignored
    step(); m_req = 2'b01; m_addr[0 +: AW] = 32'h0000_0100; s_ready = 4'b1110;
    settle(); check("d4_gnt", 64'(m_gnt), 64'h1);
    for (int i = 0; i < TO; i++) begin
      step(); m_req = '0;
      settle(); check("d4_sreq_held", 64'(s_req), 64'h1);
    end
    step(); settle();
    check("d4_rvalid", 64'(m_rvalid), 64'h1);
    check("d4_err",    64'(m_err),    64'h1);
    check("d4_rdata",  64'(m_rdata),  64'h0);
    check("d4_sreq_off", 64'(s_req),  64'h0);
    step(); s_ready = '0; settle();

    // Reset in the middle of an access aborts it silently
    step(); m_req = 2'b10; m_we = 2'b00; m_addr[AW +: AW] = 32'h0000_0200;
    settle(); check("d5_gnt", 64'(m_gnt), 64'h2);
    step(); m_req = '0;
    settle(); check("d5_sreq", 64'(s_req), 64'h1);
    step(); rst_n = 1'b0;
    settle();
    step(); rst_n = 1'b1;
    settle();
    check("d5_sreq_rst",   64'(s_req),    64'h0);
    check("d5_rvalid_rst", 64'(m_rvalid), 64'h0);
    check("d5_saddr_rst",  64'(s_addr),   64'h0);
    step(); settle(); check("d5_no_late_rvalid", 64'(m_rvalid), 64'h0);

    // Both masters requesting continuously: alternate, one completion per 3 cycles
    for (int c = 0; c < 12; c++) begin
      step();
      m_req = 2'b11; m_we = 2'b00; s_ready = 4'b1111;
      m_addr[0 +: AW] = 32'h1000_0000; m_addr[AW +: AW] = 32'h1000_0040;
      settle();
      check("d6_gnt",    64'(m_gnt),    (c % 3 == 0) ? (((c / 3) % 2 == 0) ? 64'h1 : 64'h2) : 64'h0);
      check("d6_rvalid", 64'(m_rvalid), (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 64'h1 : 64'h2) : 64'h0);
    end
    step(); m_req = '0; s_ready = '0; settle();
    step(); settle();
    gseen = '0;

    // Randomized traffic checked by the reference model each cycle
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c % 256 == 0) begin
        case ($urandom % 4)
          0:       pr = 3;
          1:       pr = 25;
          2:       pr = 60;
          default: pr = 100;
        endcase
      end
      rst_n = ($urandom % 600) != 0;
      for (int j = 0; j < NS; j++) begin
        s_ready[j] = ($urandom % 100) < pr;
        s_rdata[j*DW +: DW] = DW'($urandom);
      end
      for (int k = 0; k < NM; k++) begin
        if (!m_req[k]) begin
          if (($urandom % 100) < 30) new_req(k);
        end else if (gseen[k]) begin
          if ($urandom % 2 == 0) new_req(k);
          else m_req[k] = 1'b0;
        end
      end
      settle();
      gseen = m_gnt;
    end
    step(); m_req = '0; rst_n = 1'b1; settle();
    step(); settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
